// File: rtl/vga_pkg.sv
// Shared VGA constants, RGB332 colour type and pattern-mode encodings.
// Pure declarations: no latency, no backpressure.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int BOX_SIZE = 32;
  localparam int SPEED    = 1;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t C_WHITE   = '{r: 3'd7, g: 3'd7, b: 2'd3};
  localparam rgb_t C_YELLOW  = '{r: 3'd7, g: 3'd7, b: 2'd0};
  localparam rgb_t C_CYAN    = '{r: 3'd0, g: 3'd7, b: 2'd3};
  localparam rgb_t C_GREEN   = '{r: 3'd0, g: 3'd7, b: 2'd0};
  localparam rgb_t C_MAGENTA = '{r: 3'd7, g: 3'd0, b: 2'd3};
  localparam rgb_t C_RED     = '{r: 3'd7, g: 3'd0, b: 2'd0};
  localparam rgb_t C_BLUE    = '{r: 3'd0, g: 3'd0, b: 2'd3};
  localparam rgb_t C_BLACK   = '{r: 3'd0, g: 3'd0, b: 2'd0};

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_t;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position, stepped once per frame event and clamped to stay fully on screen.
// Position updates on the edge that sees frame_evt; no backpressure.
module vga_box_mover
  import vga_pkg::*;
(
  input  logic       PixClk,
  input  logic       Locked,
  input  logic       frame_evt,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam logic [9:0] BOX_W = 10'(BOX_SIZE);
  localparam logic [9:0] STEP  = 10'(SPEED);
  localparam logic [9:0] X_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] Y_LIM = 10'(V_ACTIVE);

  logic       dx_pos, dy_pos;
  logic       dx_nxt, dy_nxt;
  logic [9:0] x_nxt, y_nxt;

  // Returns {direction_is_positive, new_position}; worst-case sum is lim+SPEED, fits 10 bits.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic fwd,
                                            input logic [9:0] lim);
    logic [10:0] r;
    if (fwd && (pos + BOX_W + STEP > lim)) r = {1'b0, lim - BOX_W};
    else if (!fwd && (pos < STEP))         r = {1'b1, 10'd0};
    else if (fwd)                          r = {1'b1, pos + STEP};
    else                                   r = {1'b0, pos - STEP};
    return r;
  endfunction

  always_comb begin
    {dx_nxt, x_nxt} = step_axis(x, dx_pos, X_LIM);
    {dy_nxt, y_nxt} = step_axis(y, dy_pos, Y_LIM);
  end

  always_ff @(posedge PixClk) begin
    if (!Locked) begin
      x      <= '0;
      y      <= '0;
      dx_pos <= 1'b1;
      dy_pos <= 1'b1;
    end else if (frame_evt) begin
      x      <= x_nxt;
      y      <= y_nxt;
      dx_pos <= dx_nxt;
      dy_pos <= dy_nxt;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage behind the VGA timing controller; RGB332 out with re-aligned syncs.
// Latency 2 cycles for colour, syncs and FrameTick alike; free-running, no backpressure.
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic       PixClk,
  input  logic       Locked,
  input  logic [9:0] Hcounter,
  input  logic [9:0] Vcounter,
  input  logic       Hsync_in,
  input  logic       Vsync_in,
  input  logic [1:0] ModeSel,
  output logic [2:0] Red,
  output logic [2:0] Green,
  output logic [1:0] Blue,
  output logic       Hsync,
  output logic       Vsync,
  output logic       FrameTick
);

  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] BOX_W = 10'(BOX_SIZE);

  mode_t      mode;
  logic [7:0] frame_cnt;
  logic       frame_evt;
  logic [9:0] box_x, box_y;

  // First blank line start: the only point where mode/frame state may change.
  assign frame_evt = (Hcounter == 10'd0) && (Vcounter == V_ACT);

  always_ff @(posedge PixClk) begin
    if (!Locked) begin
      mode      <= MODE_BARS;
      frame_cnt <= '0;
    end else if (frame_evt) begin
      mode      <= mode_t'(ModeSel);
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  vga_box_mover u_box (
    .PixClk    (PixClk),
    .Locked    (Locked),
    .frame_evt (frame_evt),
    .x         (box_x),
    .y         (box_y)
  );

  logic [2:0] bar_idx;
  logic       active, in_box;

  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--)
      if (Hcounter < 10'((i + 1) * (H_ACTIVE / 8))) bar_idx = 3'(i);
  end

  assign active = (Hcounter < H_ACT) && (Vcounter < V_ACT);
  assign in_box = (Hcounter >= box_x) && (Hcounter < box_x + BOX_W) &&
                  (Vcounter >= box_y) && (Vcounter < box_y + BOX_W);

  mode_t      s1_mode;
  logic       s1_active, s1_chk, s1_box, s1_hs, s1_vs, s1_ft;
  logic [2:0] s1_bar;
  rgb_t       s1_grad;

  always_ff @(posedge PixClk) begin
    if (!Locked) begin
      s1_mode   <= MODE_BARS;
      s1_active <= 1'b0;
      s1_chk    <= 1'b0;
      s1_box    <= 1'b0;
      s1_bar    <= '0;
      s1_grad   <= C_BLACK;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_ft     <= 1'b0;
    end else begin
      s1_mode   <= mode;
      s1_active <= active;
      s1_chk    <= Hcounter[5] ^ Vcounter[5] ^ frame_cnt[5];
      s1_box    <= in_box;
      s1_bar    <= bar_idx;
      s1_grad   <= '{r: Hcounter[9:7], g: Vcounter[8:6], b: frame_cnt[7:6]};
      s1_hs     <= Hsync_in;
      s1_vs     <= Vsync_in;
      s1_ft     <= frame_evt;
    end
  end

  rgb_t pix;

  always_comb begin
    pix = C_BLACK;
    if (s1_active) begin
      case (s1_mode)
        MODE_BARS:  pix = bar_colour(s1_bar);
        MODE_CHECK: pix = s1_chk ? C_BLACK : C_WHITE;
        MODE_BOX:   pix = s1_box ? C_RED : C_BLUE;
        MODE_GRAD:  pix = s1_grad;
        default:    pix = C_BLACK;
      endcase
    end
  end

  always_ff @(posedge PixClk) begin
    if (!Locked) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      Hsync     <= 1'b0;
      Vsync     <= 1'b0;
      FrameTick <= 1'b0;
    end else begin
      Red       <= pix.r;
      Green     <= pix.g;
      Blue      <= pix.b;
      Hsync     <= s1_hs;
      Vsync     <= s1_vs;
      FrameTick <= s1_ft;
    end
  end

endmodule
